// File: rtl/conv_sweep_pkg.sv
// Shared types and defaults for the converter sweep sequencer.
package conv_sweep_pkg;

  // Default code width: the converter has four inputs (a..d) and four outputs (e..h).
  localparam int CONV_W = 4;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_EMIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/conv_sweep_ctrl_timer.sv
// Settle down-counter for the sweep sequencer.
// A load presets the count to SETTLE-1, dec counts down and stops at zero,
// and zero tells the sequencer that the converter output may be sampled.
module sweep_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load takes priority, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(SETTLE - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/conv_sweep_ctrl.sv
// Deterministic sweep sequencer for the 4-bit code converter.
// Walks CODE_LO..CODE_HI, holds each code for SETTLE cycles, captures the
// converter result and offers {code, result} on a valid/ready handshake.
// Optional result checker: define CONV_SWEEP_CHECK_EN to add exp_val,
// res_err and a saturating err_cnt.
module conv_sweep_ctrl
  import conv_sweep_pkg::*;
#(
  parameter int W       = CONV_W,
  parameter int SETTLE  = 2,
  parameter int CODE_LO = 0,
  parameter int CODE_HI = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  output logic [W-1:0] conv_in,
  input  logic [W-1:0] conv_out,
  output logic [W-1:0] res_code,
  output logic [W-1:0] res_val,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy,
  output logic         done
`ifdef CONV_SWEEP_CHECK_EN
  ,
  input  logic [W-1:0] exp_val,
  output logic [W:0]   err_cnt,
  output logic         res_err
`endif
);

  if (SETTLE < 1) begin : g_bad_settle
    $error("conv_sweep_ctrl: SETTLE must be at least 1");
  end
  if ((CODE_LO < 0) || (CODE_LO > CODE_HI) || (CODE_HI > (2 ** W) - 1)) begin : g_bad_range
    $error("conv_sweep_ctrl: need 0 <= CODE_LO <= CODE_HI <= 2**W-1");
  end

  localparam logic [W-1:0] LO_CODE = W'(CODE_LO);
  localparam logic [W-1:0] HI_CODE = W'(CODE_HI);

  state_e       state_q, state_d;
  logic [W-1:0] conv_in_q, conv_in_d;
  logic [W-1:0] res_code_q, res_code_d;
  logic [W-1:0] res_val_q, res_val_d;
  logic         res_valid_q, res_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         tmr_load;
  logic         tmr_dec;
  logic         tmr_zero;

`ifdef CONV_SWEEP_CHECK_EN
  logic [W:0]   err_cnt_q, err_cnt_d;
  logic         res_err_q, res_err_d;
`else
  // Checker disabled: no comparison state exists in this build.
`endif

  sweep_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(tmr_load),
    .dec (tmr_dec),
    .zero(tmr_zero)
  );

  // Next-state and next-output logic; abort overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    conv_in_d   = conv_in_q;
    res_code_d  = res_code_q;
    res_val_d   = res_val_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
`ifdef CONV_SWEEP_CHECK_EN
    err_cnt_d   = err_cnt_q;
    res_err_d   = res_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          conv_in_d = LO_CODE;
          tmr_load  = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_SETTLE;
`ifdef CONV_SWEEP_CHECK_EN
          err_cnt_d = '0;
`endif
        end
      end

      S_SETTLE: begin
        if (tmr_zero) begin
          res_code_d  = conv_in_q;
          res_val_d   = conv_out;
          res_valid_d = 1'b1;
          state_d     = S_EMIT;
`ifdef CONV_SWEEP_CHECK_EN
          res_err_d   = (conv_out != exp_val);
`endif
        end else begin
          tmr_dec = 1'b1;
        end
      end

      S_EMIT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
`ifdef CONV_SWEEP_CHECK_EN
          if (res_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + (W + 1)'(1);
          end
`endif
          if (conv_in_q == HI_CODE) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            conv_in_d = conv_in_q + W'(1);
            tmr_load  = 1'b1;
            state_d   = S_SETTLE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      conv_in_d   = conv_in_q;
      res_code_d  = res_code_q;
      res_val_d   = res_val_q;
      res_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      tmr_load    = 1'b0;
      tmr_dec     = 1'b0;
`ifdef CONV_SWEEP_CHECK_EN
      err_cnt_d   = err_cnt_q;
      res_err_d   = res_err_q;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      conv_in_q   <= '0;
      res_code_q  <= '0;
      res_val_q   <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CONV_SWEEP_CHECK_EN
      err_cnt_q   <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      conv_in_q   <= conv_in_d;
      res_code_q  <= res_code_d;
      res_val_q   <= res_val_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CONV_SWEEP_CHECK_EN
      err_cnt_q   <= err_cnt_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign conv_in   = conv_in_q;
  assign res_code  = res_code_q;
  assign res_val   = res_val_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef CONV_SWEEP_CHECK_EN
  assign err_cnt   = err_cnt_q;
  assign res_err   = res_err_q;
`endif

endmodule

// File: tb/tb_conv_sweep_ctrl.sv
// Self-checking bench for conv_sweep_ctrl with a Gray-code converter model.
// Also exercises the checker ports when CONV_SWEEP_CHECK_EN is defined.
module tb_conv_sweep_ctrl;

  // The converter under sequencer control: binary to Gray.
  function automatic logic [3:0] gray(input logic [3:0] c);
    return c ^ (c >> 1);
  endfunction

  logic       clk = 1'b0;
  logic       rst, start, abort, res_ready;
  logic [3:0] conv_in, conv_out, res_code, res_val;
  logic       res_valid, busy, done;

  logic       start2, abort2, ready2;
  logic [3:0] conv_in2, conv_out2, res_code2, res_val2;
  logic       res_valid2, busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign conv_out  = gray(conv_in);
  assign conv_out2 = gray(conv_in2);

`ifdef CONV_SWEEP_CHECK_EN
  logic       corrupt_en;
  logic [3:0] exp_val, exp_val2;
  logic [4:0] err_cnt, err_cnt2;
  logic       res_err, res_err2;
  assign exp_val  = (corrupt_en && (conv_in == 4'd3 || conv_in == 4'd12)) ?
                    (gray(conv_in) ^ 4'd1) : gray(conv_in);
  assign exp_val2 = gray(conv_in2);
`endif

  conv_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .conv_in(conv_in), .conv_out(conv_out),
    .res_code(res_code), .res_val(res_val), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .done(done)
`ifdef CONV_SWEEP_CHECK_EN
    , .exp_val(exp_val), .err_cnt(err_cnt), .res_err(res_err)
`endif
  );

  conv_sweep_ctrl #(.W(4), .SETTLE(1), .CODE_LO(9), .CODE_HI(9)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .conv_in(conv_in2), .conv_out(conv_out2),
    .res_code(res_code2), .res_val(res_val2), .res_valid(res_valid2),
    .res_ready(ready2), .busy(busy2), .done(done2)
`ifdef CONV_SWEEP_CHECK_EN
    , .exp_val(exp_val2), .err_cnt(err_cnt2), .res_err(res_err2)
`endif
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances and check every registered output is cleared.
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b0;
`ifdef CONV_SWEEP_CHECK_EN
    corrupt_en = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({conv_in, res_code, res_val} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h %h, want 000", conv_in, res_code, res_val);
    end
    checks++;
    if ({res_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got v/b/d=%b, want 000", {res_valid, busy, done});
    end
    checks++;
    if ({conv_in2, res_valid2, busy2, done2} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut2: got %b, want 0", {conv_in2, res_valid2, busy2, done2});
    end
`ifdef CONV_SWEEP_CHECK_EN
    checks++;
    if (err_cnt !== 5'd0 || res_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_err: got cnt=%0d err=%b, want 0 0", err_cnt, res_err);
    end
`endif
  endtask

  // start and abort together in IDLE: abort wins, nothing starts.
  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL start_abort_idle: busy=%b valid=%b, want 0 0", busy, res_valid);
      end
      tick();
    end
  endtask

  // Full sweep with ready tied high: pair k appears at cycle 3*(k+1), done at 49.
  task automatic test_gray_sweep();
    int cyc, pairs, done_cyc;
    res_ready = 1'b1; start = 1'b1;
    cyc = 0; pairs = 0; done_cyc = -1;
    for (int n = 0; n < 200 && done_cyc < 0; n++) begin
      tick(); cyc++; start = 1'b0;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1 || conv_in !== 4'd0) begin
          errors++;
          $display("[TB] FAIL sweep_first: busy=%b conv_in=%0d, want 1 0", busy, conv_in);
        end
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (res_code !== pairs[3:0] || res_val !== gray(pairs[3:0]) || cyc != 3 * (pairs + 1)) begin
          errors++;
          $display("[TB] FAIL sweep_pair: code=%0d val=%0d cyc=%0d, want %0d %0d %0d",
                   res_code, res_val, cyc, pairs, gray(pairs[3:0]), 3 * (pairs + 1));
        end
        pairs++;
      end
      if (done === 1'b1) done_cyc = cyc;
    end
    checks++;
    if (pairs != 16 || done_cyc != 49 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sweep_done: pairs=%0d done_cyc=%0d busy=%b, want 16 49 0",
               pairs, done_cyc, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || conv_in !== 4'd15) begin
      errors++;
      $display("[TB] FAIL sweep_after: done=%b conv_in=%0d, want 0 15", done, conv_in);
    end
  endtask

  // Random backpressure plus a forced 5-cycle stall on code 7.
  task automatic test_backpressure();
    int exp_code, pairs, stall7;
    logic fin;
    exp_code = 0; pairs = 0; stall7 = 0; fin = 1'b0;
    res_ready = 1'b1; start = 1'b1;
    for (int n = 0; n < 2000 && !fin; n++) begin
      tick(); start = 1'b0;
      if (res_valid === 1'b1) begin
        checks++;
        if (res_code !== exp_code[3:0] || res_val !== gray(exp_code[3:0]) || conv_in !== exp_code[3:0]) begin
          errors++;
          $display("[TB] FAIL bp_hold: code=%0d val=%0d conv_in=%0d, want code %0d",
                   res_code, res_val, conv_in, exp_code);
        end
        if (exp_code == 7 && stall7 < 5) begin
          res_ready = 1'b0;
          stall7++;
        end else begin
          res_ready = ($urandom_range(0, 3) != 0);
        end
        if (res_ready) begin
          exp_code++;
          pairs++;
        end
      end else begin
        if (busy === 1'b1) begin
          checks++;
          if (conv_in !== exp_code[3:0]) begin
            errors++;
            $display("[TB] FAIL bp_conv_in: got %0d, want %0d", conv_in, exp_code);
          end
        end
        res_ready = $urandom_range(0, 1);
      end
      if (done === 1'b1) fin = 1'b1;
    end
    checks++;
    if (!fin || pairs != 16 || stall7 != 5) begin
      errors++;
      $display("[TB] FAIL bp_total: fin=%b pairs=%0d stall7=%0d, want 1 16 5", fin, pairs, stall7);
    end
    res_ready = 1'b1;
    tick();
  endtask

  // Abort on the second settle cycle of code 4, then restart from 0.
  task automatic test_abort();
    int s4, bad;
    s4 = 0; bad = 0;
    res_ready = 1'b1; start = 1'b1;
    for (int n = 0; n < 100 && s4 < 2; n++) begin
      tick(); start = 1'b0;
      if (busy === 1'b1 && res_valid === 1'b0 && conv_in === 4'd4) s4++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (s4 != 2 || busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || conv_in !== 4'd4) begin
      errors++;
      $display("[TB] FAIL abort_settle: s4=%0d busy=%b valid=%b done=%b conv_in=%0d, want 2 0 0 0 4",
               s4, busy, res_valid, done, conv_in);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: %0d active cycles after abort, want 0", bad);
    end
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    checks++;
    if (res_valid !== 1'b1 || res_code !== 4'd0 || res_val !== 4'd0) begin
      errors++;
      $display("[TB] FAIL abort_restart: valid=%b code=%0d val=%0d, want 1 0 0", res_valid, res_code, res_val);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || conv_in !== 4'd0) begin
      errors++;
      $display("[TB] FAIL abort_drop: valid=%b busy=%b conv_in=%0d, want 0 0 0", res_valid, busy, conv_in);
    end
    tick();
  endtask

  // Abort at a random point; with ready high the code at cycle c is (c-1)/3.
  task automatic test_random_abort();
    int cstop, want;
    res_ready = 1'b1;
    for (int it = 0; it < 4; it++) begin
      cstop = $urandom_range(1, 49);
      want = (cstop - 1) / 3;
      if (want > 15) want = 15;
      start = 1'b1;
      for (int c = 1; c <= cstop; c++) begin
        tick(); start = 1'b0;
      end
      checks++;
      if (conv_in !== want[3:0]) begin
        errors++;
        $display("[TB] FAIL rabort_code: cyc=%0d conv_in=%0d, want %0d", cstop, conv_in, want);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || conv_in !== want[3:0]) begin
        errors++;
        $display("[TB] FAIL rabort_idle: busy=%b valid=%b done=%b conv_in=%0d, want 0 0 0 %0d",
                 busy, res_valid, done, conv_in, want);
      end
      tick();
    end
  endtask

  // start pulses during EMIT must not disturb the running sweep.
  task automatic test_start_during_emit();
    int exp_code, pairs, pulses, bad;
    logic fin;
    exp_code = 0; pairs = 0; pulses = 0; bad = 0; fin = 1'b0;
    res_ready = 1'b1; start = 1'b1;
    for (int n = 0; n < 2000 && !fin; n++) begin
      tick(); start = 1'b0;
      if (res_valid === 1'b1) begin
        if (res_code !== exp_code[3:0]) bad++;
        res_ready = $urandom_range(0, 1);
        if (res_code !== 4'd15 && $urandom_range(0, 1) == 1) begin
          start = 1'b1;
          pulses++;
        end
        if (res_ready) begin
          exp_code++;
          pairs++;
        end
      end else begin
        res_ready = 1'b1;
      end
      if (done === 1'b1) fin = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!fin || pairs != 16 || bad != 0 || pulses == 0) begin
      errors++;
      $display("[TB] FAIL emit_start: fin=%b pairs=%0d bad=%0d pulses=%0d, want 1 16 0 >0",
               fin, pairs, bad, pulses);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy !== 1'b0 || res_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL emit_start_idle: %0d busy cycles after done, want 0", bad);
    end
  endtask

  // Single-code sweep on the second instance (CODE_LO=CODE_HI=9, SETTLE=1).
  task automatic test_single_code();
    ready2 = 1'b1; start2 = 1'b1;
    tick(); start2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1 || res_valid2 !== 1'b0 || conv_in2 !== 4'd9) begin
      errors++;
      $display("[TB] FAIL single_settle: busy=%b valid=%b conv_in=%0d, want 1 0 9", busy2, res_valid2, conv_in2);
    end
    tick();
    checks++;
    if (res_valid2 !== 1'b1 || res_code2 !== 4'd9 || res_val2 !== gray(4'd9)) begin
      errors++;
      $display("[TB] FAIL single_pair: valid=%b code=%0d val=%0d, want 1 9 %0d",
               res_valid2, res_code2, res_val2, gray(4'd9));
    end
    tick();
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || res_valid2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done: done=%b busy=%b valid=%b, want 1 0 0", done2, busy2, res_valid2);
    end
    tick();
    checks++;
    if (done2 !== 1'b0 || conv_in2 !== 4'd9) begin
      errors++;
      $display("[TB] FAIL single_after: done=%b conv_in=%0d, want 0 9", done2, conv_in2);
    end
  endtask

`ifdef CONV_SWEEP_CHECK_EN
  // Expected value corrupted for codes 3 and 12: exactly two flagged pairs.
  task automatic test_checker();
    logic fin;
    fin = 1'b0;
    corrupt_en = 1'b1; res_ready = 1'b1; start = 1'b1;
    for (int n = 0; n < 200 && !fin; n++) begin
      tick(); start = 1'b0;
      if (res_valid === 1'b1) begin
        checks++;
        if (res_err !== (res_code == 4'd3 || res_code == 4'd12)) begin
          errors++;
          $display("[TB] FAIL chk_flag: code=%0d res_err=%b", res_code, res_err);
        end
      end
      if (done === 1'b1) begin
        fin = 1'b1;
        checks++;
        if (err_cnt !== 5'd2) begin
          errors++;
          $display("[TB] FAIL chk_count: err_cnt=%0d, want 2", err_cnt);
        end
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("[TB] FAIL chk_timeout: no done pulse");
    end
    corrupt_en = 1'b0;
    tick();
    start = 1'b1;
    tick(); start = 1'b0;
    checks++;
    if (err_cnt !== 5'd0) begin
      errors++;
      $display("[TB] FAIL chk_clear: err_cnt=%0d after start, want 0", err_cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_start_abort_idle();
    test_gray_sweep();
    test_backpressure();
    test_abort();
    test_random_abort();
    test_start_during_emit();
    test_single_code();
`ifdef CONV_SWEEP_CHECK_EN
    test_checker();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
